regfile_access_ctrl: RTL and testbench
======================================

// Module: regfile_access_ctrl
// PURPOSE
//  Initiator side of the integer register-file port (ra1/ra2/wa1/wd1/we/re -> rd1/rd2).
//  Accepts operand-read requests from decode and writeback requests from the pipeline.
//  Buffers writebacks in a small FIFO and arbitrates one regfile op per cycle (read or write,
//  never both), so the regfile's same-address read/write suppression never triggers.
//  Resolves RAW hazards against buffered writes by stalling, or by forwarding with FWD_EN.
// PARAMETERS
//  XLEN      32  data width
//  WB_DEPTH  4   writeback FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1     clock, all state on posedge
//  rst_n      in   1     asynchronous active-low reset
//  req_valid  in   1     operand read request
//  req_ready  out  1     request accepted when valid&ready at posedge
//  req_rs1    in   5     source reg 1
//  req_rs2    in   5     source reg 2
//  rsp_valid  out  1     response valid (no backpressure)
//  rsp_rs1    out  XLEN  rs1 value
//  rsp_rs2    out  XLEN  rs2 value
//  wb_valid   in   1     writeback request
//  wb_ready   out  1     = !fifo_full
//  wb_rd      in   5     destination reg
//  wb_data    in   XLEN  writeback data
//  rf_ra1/rf_ra2/rf_wa1  out  5     regfile addresses
//  rf_wd1     out  XLEN  regfile write data
//  rf_we/rf_re           out  1     regfile write/read enables
//  rf_rd1/rf_rd2         in   XLEN  regfile read data, valid cycle after rf_re
//  wb_pending out  1     FIFO non-empty (fence/drain status)
// BEHAVIOUR
//  Reset (rst_n low, async): FIFO empty, rsp_valid=0, state IDLE; rf_we=rf_re=0 and
//   req_ready=0 forced while rst_n low; rsp_rs1/rs2=0; wb_ready=1 after release.
//  State (registered last op): IDLE -> RD (read issued) | WR (head write issued) | IDLE.
//  Per-cycle arbitration, evaluated combinationally:
//   1. fifo_full: drain head (rf_we=1), req_ready=0 -> WR.
//   2. req_valid & !hazard: req_ready=1, rf_re=1, rf_ra1=rs1, rf_ra2=rs2 -> RD.
//   3. fifo non-empty: drain head -> WR.   4. else IDLE, rf_we=rf_re=0.
//  hazard: rs1 or rs2 nonzero and equal to wb_rd of any valid FIFO entry.
//  Latency: request accepted at edge N -> rsp_valid=1 for exactly the cycle after N;
//   back-to-back reads give one response per cycle. rsp_rsX = 0 if rsX==0, else rf_rdX.
//  Ordering: a wb accepted in the same cycle as a read is younger than that read.
//  wb to x0: accepted (wb_ready honoured) and discarded, never enqueued.
//  Enqueue and dequeue in one cycle: occupancy unchanged; pointers wrap mod WB_DEPTH.
//  Writes drain strictly in FIFO order; rf_wa1/rf_wd1 = head entry when rf_we=1.
//  rf_re and rf_we never both 1.  Reset mid-operation: pending writes and any
//   in-flight response are dropped; rsp_valid low from reset assertion.
// CONFIGURATION
//  FWD_EN defined: hazard never stalls; at acceptance each operand matching the FIFO
//   snapshots the youngest matching entry's data into a register; rsp_rsX returns that
//   snapshot instead of rf_rdX. Rule 1 (full) still blocks requests.
//  FWD_EN undefined: hazard deasserts req_ready until all matching entries drain.
// TESTING
//  Reset then read rs1=1,rs2=2 with regfile x1=5,x2=10 -> rsp_valid 1 cycle later, 5/10.
//  wb x3=0xA5 then read rs1=3: no FWD_EN -> req_ready=0 until drain, rsp 0xA5;
//   FWD_EN -> accepted next cycle, rsp 0xA5 while x3 still in FIFO.
//  Enqueue 4 writes with req_valid held: full -> req_ready=0, drain one, rf_we/rf_re never
//   both 1, writes reach regfile in order x4..x7.
//  wb x0=0xFF, read rs1=0 -> no rf_we, rsp_rs1=0.
//  Two writes to x5 (1 then 2) + read x5 with FWD_EN -> rsp 2; pulse rst_n mid-drain ->
//   FIFO empty, rsp_valid=0, wb_pending=0.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//   Initiator side of the integer register-file port. Operand reads from decode
//   and writebacks from the pipeline share a single regfile op per cycle: a
//   cycle either reads (rf_re) or writes (rf_we), never both. Writebacks wait in
//   a small FIFO and drain in order whenever no read claims the port. A full
//   FIFO always drains and blocks reads.
//
//   Build option: define FWD_EN to forward buffered write data to reads that
//   hit the FIFO instead of stalling them. Without FWD_EN, a read whose source
//   matches a buffered write is held off (req_ready=0) until that write drains.
//
//   Handshakes: a request or writeback transfers on a rising clk edge where its
//   valid and ready are both 1. The response has no backpressure. rsp_valid is
//   high for exactly the cycle after the read was accepted.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/ready/rs1/rs2    operand read request
//   rsp_valid/rs1/rs2          operand response (one cycle after acceptance)
//   wb_valid/ready/rd/data     writeback request (wb_ready = !fifo_full)
//   rf_ra1/ra2/wa1/wd1/we/re   regfile command outputs
//   rf_rd1/rf_rd2              regfile read data, valid the cycle after rf_re
//   wb_pending                 writeback FIFO is non-empty
module regfile_access_ctrl #(
  parameter int XLEN     = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_rs1,
  input  logic [4:0]      req_rs2,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rs1,
  output logic [XLEN-1:0] rsp_rs2,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [4:0]      rf_ra1,
  output logic [4:0]      rf_ra2,
  output logic [4:0]      rf_wa1,
  output logic [XLEN-1:0] rf_wd1,
  output logic            rf_we,
  output logic            rf_re,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic            wb_pending
);

  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

  // Last regfile op issued. ST_RD means a response is due this cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      fifo_rd_q   [WB_DEPTH];
  logic [4:0]      fifo_rd_d   [WB_DEPTH];
  logic [XLEN-1:0] fifo_data_q [WB_DEPTH];
  logic [XLEN-1:0] fifo_data_d [WB_DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW:0]     count_q, count_d;
  logic            rs1_nz_q, rs1_nz_d, rs2_nz_q, rs2_nz_d;

  logic                fifo_full, fifo_empty;
  logic [WB_DEPTH-1:0] slot_valid;
  logic                hit1, hit2, stall, accept, drain, enq;

`ifdef FWD_EN
  logic            fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [XLEN-1:0] fwd_data1_q, fwd_data1_d, fwd_data2_q, fwd_data2_d;
  logic [PW-1:0]   idx;
`endif

  assign fifo_full  = (count_q == (PW+1)'(WB_DEPTH));
  assign fifo_empty = (count_q == '0);

  // An entry is live when its distance from the head is below the occupancy.
  // x0 never matches: it is not a real dependency.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      slot_valid[i] = {1'b0, PW'(i) - head_q} < count_q;
      if (slot_valid[i] && (fifo_rd_q[i] == req_rs1)) hit1 = 1'b1;
      if (slot_valid[i] && (fifo_rd_q[i] == req_rs2)) hit2 = 1'b1;
    end
    hit1 = hit1 && (req_rs1 != 5'd0);
    hit2 = hit2 && (req_rs2 != 5'd0);
  end

`ifdef FWD_EN
  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_data1_d = '0;
    fwd_data2_d = '0;
    idx         = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (((PW+1)'(k) < count_q) && (fifo_rd_q[idx] == req_rs1)) fwd_data1_d = fifo_data_q[idx];
      if (((PW+1)'(k) < count_q) && (fifo_rd_q[idx] == req_rs2)) fwd_data2_d = fifo_data_q[idx];
    end
  end
  assign stall = 1'b0;
`else
  assign stall = hit1 || hit2;
`endif

  always_comb begin
    wb_ready   = !fifo_full;
    wb_pending = !fifo_empty;
    // Reads win over a non-full FIFO; a full FIFO always drains.
    req_ready  = rst_n && !fifo_full && !stall;
    accept     = req_valid && req_ready;
    drain      = rst_n && !fifo_empty && !accept;
    // A writeback to x0 is handshaken but dropped.
    enq        = wb_valid && wb_ready && (wb_rd != 5'd0);

    rf_re  = accept;
    rf_ra1 = req_rs1;
    rf_ra2 = req_rs2;
    rf_we  = drain;
    rf_wa1 = fifo_rd_q[head_q];
    rf_wd1 = fifo_data_q[head_q];

    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    if (enq) begin
      fifo_rd_d[tail_q]   = wb_rd;
      fifo_data_d[tail_q] = wb_data;
    end
    tail_d  = enq   ? tail_q + PW'(1) : tail_q;
    head_d  = drain ? head_q + PW'(1) : head_q;
    count_d = count_q + (PW+1)'(enq) - (PW+1)'(drain);

    rs1_nz_d = (req_rs1 != 5'd0);
    rs2_nz_d = (req_rs2 != 5'd0);

    if (accept)     state_d = ST_RD;
    else if (drain) state_d = ST_WR;
    else            state_d = ST_IDLE;
  end

`ifdef FWD_EN
  assign fwd1_d = accept && hit1;
  assign fwd2_d = accept && hit2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rs1_nz_q <= 1'b0;
      rs2_nz_q <= 1'b0;
`ifdef FWD_EN
      fwd1_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      fwd_data1_q <= '0;
      fwd_data2_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rs1_nz_q <= rs1_nz_d;
      rs2_nz_q <= rs2_nz_d;
`ifdef FWD_EN
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      fwd_data1_q <= fwd_data1_d;
      fwd_data2_q <= fwd_data2_d;
`endif
    end
  end

  // FIFO storage is qualified by the pointers and needs no reset.
  always_ff @(posedge clk) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
  end

  assign rsp_valid = (state_q == ST_RD);

  always_comb begin
    rsp_rs1 = '0;
    rsp_rs2 = '0;
    if (state_q == ST_RD) begin
`ifdef FWD_EN
      if (fwd1_q)        rsp_rs1 = fwd_data1_q;
      else if (rs1_nz_q) rsp_rs1 = rf_rd1;
      if (fwd2_q)        rsp_rs2 = fwd_data2_q;
      else if (rs2_nz_q) rsp_rs2 = rf_rd2;
`else
      if (rs1_nz_q) rsp_rs1 = rf_rd1;
      if (rs2_nz_q) rsp_rs2 = rf_rd2;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;
  localparam int XLEN = 32;
  localparam int D    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready;
  logic [4:0]      req_rs1, req_rs2;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rs1, rsp_rs2;
  logic            wb_valid, wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rf_ra1, rf_ra2, rf_wa1;
  logic [XLEN-1:0] rf_wd1;
  logic            rf_we, rf_re;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic            wb_pending;

  // clock / reset
  always #5 clk = ~clk;

  regfile_access_ctrl #(.XLEN(XLEN), .WB_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_rs1(rsp_rs1), .rsp_rs2(rsp_rs2),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa1(rf_wa1), .rf_wd1(rf_wd1),
    .rf_we(rf_we), .rf_re(rf_re), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_pending(wb_pending)
  );

  // Simple regfile: synchronous write, read data registered one cycle after rf_re.
  logic [XLEN-1:0] mem [32];
  always @(posedge clk) begin
    if (rf_we) mem[rf_wa1] <= rf_wd1;
    if (rf_re) begin
      rf_rd1 <= mem[rf_ra1];
      rf_rd2 <= mem[rf_ra2];
    end
  end

  // Reference model: architectural register values in program order plus the
  // queue of writebacks that must still reach the regfile, oldest first.
  logic [XLEN-1:0] arch [32];
  logic [5+XLEN-1:0] exp_q [$];
  logic            exp_rsp_pend;
  logic [XLEN-1:0] exp_rsp1, exp_rsp2;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_hazard(input logic [4:0] a, input logic [4:0] b);
    logic h = 1'b0;
    foreach (exp_q[i]) begin
      if (a != 5'd0 && exp_q[i][5+XLEN-1:XLEN] == a) h = 1'b1;
      if (b != 5'd0 && exp_q[i][5+XLEN-1:XLEN] == b) h = 1'b1;
    end
    return h;
  endfunction

  // driver: one clock cycle of stimulus with all checks for that cycle
  task automatic do_cycle(input logic rv, input logic [4:0] r1, input logic [4:0] r2,
                          input logic wv, input logic [4:0] rd, input logic [XLEN-1:0] d);
    logic full, hz, exp_ready, acc, exp_we;
    @(negedge clk);
    req_valid = rv; req_rs1 = r1; req_rs2 = r2;
    wb_valid = wv; wb_rd = rd; wb_data = d;
    #1;
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_pend));
    if (exp_rsp_pend) begin
      check_eq("rsp_rs1", rsp_rs1, exp_rsp1);
      check_eq("rsp_rs2", rsp_rs2, exp_rsp2);
    end
    full = (exp_q.size() == D);
    hz   = model_hazard(r1, r2);
`ifdef FWD_EN
    exp_ready = !full;
`else
    exp_ready = !full && !hz;
`endif
    acc    = rv && exp_ready;
    exp_we = full || (exp_q.size() != 0 && !acc);
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("wb_ready", 32'(wb_ready), 32'(!full));
    check_eq("wb_pending", 32'(wb_pending), 32'(exp_q.size() != 0));
    check_eq("rf_re", 32'(rf_re), 32'(acc));
    check_eq("rf_we", 32'(rf_we), 32'(exp_we));
    check_eq("rd_wr_excl", 32'(rf_we && rf_re), 32'd0);
    if (acc) begin
      check_eq("rf_ra1", 32'(rf_ra1), 32'(r1));
      check_eq("rf_ra2", 32'(rf_ra2), 32'(r2));
    end
    if (exp_we) begin
      check_eq("rf_wa1", 32'(rf_wa1), 32'(exp_q[0][5+XLEN-1:XLEN]));
      check_eq("rf_wd1", rf_wd1, exp_q[0][XLEN-1:0]);
    end
    // Model update for the coming edge. A same-cycle wb is younger than the read.
    exp_rsp_pend = acc;
    if (acc) begin
      exp_rsp1 = (r1 == 5'd0) ? '0 : arch[r1];
      exp_rsp2 = (r2 == 5'd0) ? '0 : arch[r2];
    end
    if (exp_we) void'(exp_q.pop_front());
    if (wv && !full && rd != 5'd0) begin
      exp_q.push_back({rd, d});
      arch[rd] = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 1'b0;
    wb_valid  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rf_we", 32'(rf_we), 32'd0);
    check_eq("rst_rf_re", 32'(rf_re), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_wb_pending", 32'(wb_pending), 32'd0);
    check_eq("rst_rsp_rs1", rsp_rs1, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_rsp_pend = 1'b0;
    for (int i = 0; i < 32; i++) arch[i] = mem[i];
  endtask

  initial begin
    logic [XLEN-1:0] v;
    rst_n = 1'b0;
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    exp_rsp_pend = 1'b0; exp_rsp1 = '0; exp_rsp2 = '0;
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? '0 : (i == 1) ? 32'd5 : (i == 2) ? 32'd10 : $urandom;
      mem[i] <= v;
      arch[i] = v;
    end
    repeat (2) @(negedge clk);
    #1;
    check_eq("init_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("init_rsp_rs1", rsp_rs1, '0);
    check_eq("init_rf_we", 32'(rf_we), 32'd0);
    check_eq("init_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Basic read x1/x2.
    do_cycle(1, 5'd1, 5'd2, 0, 5'd0, '0);
    do_cycle(0, 5'd0, 5'd0, 0, 5'd0, '0);
    // RAW hazard against a buffered write.
    do_cycle(0, 5'd0, 5'd0, 1, 5'd3, 32'hA5);
    repeat (3) do_cycle(1, 5'd3, 5'd0, 0, 5'd0, '0);
    do_cycle(0, 5'd0, 5'd0, 0, 5'd0, '0);
    // Fill the FIFO while reads keep the port busy, then drain.
    for (int i = 0; i < 4; i++) do_cycle(1, 5'd1, 5'd2, 1, 5'(4 + i), 32'(100 + i));
    repeat (3) do_cycle(1, 5'd1, 5'd2, 0, 5'd0, '0);
    repeat (4) do_cycle(0, 5'd0, 5'd0, 0, 5'd0, '0);
    // Writeback to x0 is discarded; x0 reads as zero.
    do_cycle(0, 5'd0, 5'd0, 1, 5'd0, 32'hFF);
    do_cycle(1, 5'd0, 5'd0, 0, 5'd0, '0);
    do_cycle(0, 5'd0, 5'd0, 0, 5'd0, '0);
    // Two writes to x5, then read x5.
    do_cycle(0, 5'd0, 5'd0, 1, 5'd5, 32'd1);
    do_cycle(0, 5'd0, 5'd0, 1, 5'd5, 32'd2);
    repeat (4) do_cycle(1, 5'd5, 5'd0, 0, 5'd0, '0);
    // Reset while writes are still buffered.
    do_cycle(1, 5'd1, 5'd1, 1, 5'd6, 32'h66);
    do_cycle(1, 5'd1, 5'd1, 1, 5'd7, 32'h77);
    do_cycle(0, 5'd0, 5'd0, 1, 5'd8, 32'h88);
    do_reset();
    do_cycle(0, 5'd0, 5'd0, 0, 5'd0, '0);
    do_cycle(1, 5'd6, 5'd7, 0, 5'd0, '0);
    do_cycle(0, 5'd0, 5'd0, 0, 5'd0, '0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int blk = 0; blk < 3; blk++) begin
      for (int c = 0; c < 250; c++) begin
        do_cycle($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      end
      do_reset();
    end
    repeat (2) do_cycle(0, 5'd0, 5'd0, 0, 5'd0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
